// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master among three requesters,
// with per-transaction timeout and a GAP state that waits for m_done to fall.
module spi_arbiter #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK_M,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [3*DW-1:0] tx_data,
  output logic [2:0]      gnt,
  output logic [2:0]      ack,
  output logic [2:0]      err,
  output logic [DW-1:0]   rx_data,
  output logic            m_transmit,
  output logic            m_d_valid,
  output logic [DW-1:0]   m_data,
  input  logic            m_done,
  input  logic [DW-1:0]   m_rx,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DONE, GAP} state_t;
  localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d, idx_q, idx_d, sel, c1, c2;
  logic [2:0]    gnt_q, gnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [DW-1:0] rx_q, rx_d, md_q, md_d;
  logic          tmo;

  function automatic logic [1:0] inc3(input logic [1:0] v, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, v} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // search starts at ptr and wraps 2->0
  assign c1  = inc3(ptr_q, 2'd1);
  assign c2  = inc3(ptr_q, 2'd2);
  assign sel = req[ptr_q] ? ptr_q : req[c1] ? c1 : c2;
  assign tmo = cnt_q == TLAST;

  always_ff @(posedge CLK_M or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      md_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      md_q    <= md_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    md_d    = md_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = LOAD;
        idx_d   = sel;
        gnt_d   = 3'b001 << sel;
        md_d    = tx_data[sel*DW +: DW];
      end
      LOAD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (m_done) begin
        state_d = DONE;
        rx_d    = m_rx;
      end else if (tmo) begin
        state_d = GAP;
        gnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      DONE: begin
        state_d = GAP;
        gnt_d   = '0;
      end
      GAP: if (!m_done) begin
        state_d = IDLE;
        ptr_d   = inc3(idx_q, 2'd1);
      end
      default: state_d = IDLE;
    endcase
  end

  // err is raised in the last WAIT cycle so it still coincides with gnt
  always_comb begin
    m_transmit = state_q == LOAD || state_q == WAIT;
    m_d_valid  = state_q == WAIT;
    busy       = state_q != IDLE;
    ack        = (state_q == DONE) ? gnt_q : 3'b000;
    err        = (state_q == WAIT && !m_done && tmo) ? gnt_q : 3'b000;
    gnt        = gnt_q;
    rx_data    = rx_q;
    m_data     = md_q;
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: DW, 8, SPI word width in bits.
REQ-002 Parameter: TIMEOUT, 255, maximum CLK_M cycles in WAIT before abort; legal range 1-65535.
REQ-003 Port: CLK_M  in  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: req  in  3  per-requester transfer request, level; bit i belongs to requester i.
REQ-006 Port: tx_data  in  3*DW  per-requester transmit word; requester i owns slice [i*DW +: DW]; must stay stable while req[i]=1.
REQ-007 Port: gnt  out  3  one-hot grant, held for the whole transaction.
REQ-008 Port: ack  out  3  one-cycle completion pulse to the granted requester.
REQ-009 Port: err  out  3  one-cycle timeout pulse to the granted requester.
REQ-010 Port: rx_data  out  DW  received word, valid in the ack cycle and held until the next capture.
REQ-011 Port: m_transmit  out  1  transaction enable to the SPI master.
REQ-012 Port: m_d_valid  out  1  data-valid to the SPI master.
REQ-013 Port: m_data  out  DW  transmit word to the SPI master.
REQ-014 Port: m_done  in  1  SPI master transfer-complete.
REQ-015 Port: m_rx  in  DW  SPI master received word.
REQ-016 Port: busy  out  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, LOAD, WAIT, DONE, GAP; no other states.
REQ-018 IDLE: when req != 0, the arbiter SHALL select a requester round-robin, starting at index ptr and searching upward with wrap 2->0.
- In the same cycle it SHALL register gnt, latch that requester's tx_data into m_data, and go to LOAD.
REQ-019 LOAD (1 cycle): m_transmit=1, m_d_valid=0; next state WAIT.
REQ-020 WAIT:
- Outputs: m_transmit=1, m_d_valid=1.
- A 16-bit counter SHALL count from 0.
- If m_done=1: capture m_rx into rx_data and go to DONE.
- Else if the counter equals TIMEOUT-1: pulse err for the granted requester and go to GAP.
- If m_done=1 and the timeout fall in the same cycle, m_done SHALL win.
REQ-021 DONE (1 cycle): pulse ack for the granted requester, drive m_transmit=0 and m_d_valid=0, and go to GAP.
REQ-022 GAP:
- m_transmit=0, m_d_valid=0, gnt cleared.
- Stay until m_done=0, then go to IDLE.
- On leaving, set ptr to (granted index + 1) mod 3.
REQ-023 Latency: from req rising in IDLE to m_transmit high SHALL be exactly 2 cycles (registered grant, then LOAD).
REQ-024 m_data SHALL hold constant from LOAD through DONE; tx_data changes after the grant SHALL be ignored.
REQ-025 A requester that keeps req high after ack SHALL be re-arbitrated with the lowest priority; back-to-back grants to one requester occur only when no other req is pending.
REQ-026 Deasserting req[i] while granted SHALL NOT abort the transaction; ack[i] is still issued.
REQ-027 Outputs SHALL satisfy these invariants:
- At most one bit of gnt, ack and err is set in any cycle.
- ack and err are never set together.
- ack[i] and err[i] occur only while gnt[i]=1.
REQ-028 m_done=1 observed in IDLE or LOAD SHALL be ignored.

Reset
REQ-029 With reset=0, asynchronously:
- state = IDLE, ptr = 0, counter = 0;
- gnt = ack = err = 0;
- rx_data = 0, m_data = 0;
- m_transmit = m_d_valid = 0, busy = 0.
REQ-030 Reset asserted mid-transaction SHALL drop m_transmit immediately and issue no ack or err for that transaction.
REQ-031 After reset release, the first arbitration SHALL occur no earlier than the first rising edge at which reset=1.

Verification
REQ-032 Single request:
- Stimulus: req=001, tx_data[7:0]=8'hB3; the model returns m_rx=8'hCA with m_done 20 cycles after m_d_valid.
- Response: gnt=001; m_transmit rises 2 cycles after req; ack=001 for exactly 1 cycle; rx_data=8'hCA.
REQ-033 Simultaneous requests:
- Stimulus: req=111 held continuously, starting with ptr=0.
- Response: grant order is 0,1,2,0; each transaction ends in ack; gnt is never multi-hot.
REQ-034 Timeout:
- Stimulus: TIMEOUT=16, req=010, m_done held at 0.
- Response: err=010 exactly 16 cycles after WAIT entry; no ack; m_transmit=0 the next cycle; return to IDLE.
REQ-035 m_done and timeout together:
- Stimulus: m_done asserted in the same cycle the counter reaches TIMEOUT-1.
- Response: ack pulses, err stays 0, rx_data is updated.
REQ-036 Reset mid-WAIT:
- Stimulus: reset=0 during WAIT of requester 2.
- Response: all outputs return to reset values asynchronously; after release with req=100, a grant to requester 2 follows with ptr=0 ordering.
REQ-037 Stuck m_done:
- Stimulus: m_done held high 5 cycles after DONE.
- Response: the block stays in GAP with busy=1 until m_done falls, and no new grant is issued meanwhile.
